taylor_exp_seq: RTL and testbench
=================================

# taylor_exp_seq

Sequential IEEE-754 single-precision exponential stage for the n-th-root datapath, directly downstream of the combinational Taylor ln block. It accepts ln(x) and root degree n, forms y = ln(x)/n, range-reduces y by exponent halving, evaluates exp(r) by a Horner-form Taylor series (one term per cycle), then squares the result back s times. The output is x^(1/n). One shared arithmetic step replaces the ten-deep combinational chain used on the ln side.

## Interface
- N_TERMS, 10: Taylor terms evaluated (Horner iterations), 2..15
- MAX_SQ, 8: maximum squaring steps; larger reductions saturate
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ln_in/n_in valid
- in_ready  out  1  block can accept (state IDLE)
- ln_in  in  32  ln(x), IEEE-754 single
- n_in  in  8  root degree, unsigned integer
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- out  out  32  exp(ln_in/n_in), IEEE-754 single
- ovf  out  1  result saturated (|y| too large); valid with out_valid
- err  out  1  special-case result (see Configuration); valid with out_valid

## Operation
- States: IDLE, DIV, REDUCE, HORNER, SQUARE, DONE.
- IDLE: in_ready=1; on in_valid, register ln_in, n_in → DIV.
- DIV: y = ln_in / float(n_in). n_in is converted to float by a leading-one encoder. → REDUCE.
- REDUCE: let e = y[30:23].
  - If e ≤ 125: s=0 and r=y.
  - Otherwise s = e−125 and r = y with exponent field forced to 125, so |r| ∈ [0.25,0.5).
  - If s > MAX_SQ: out = 0x7F800000 if y positive, else 0x00000000; ovf=1; → DONE.
  - Otherwise acc=0x3F800000, i=N_TERMS, → HORNER.
- HORNER: each cycle acc ← 1 + (r·acc)/float(i); i ← i−1. When i reaches 1, the final step is taken and the block goes → SQUARE if s>0, else → DONE.
- SQUARE: each cycle acc ← acc·acc; s ← s−1. When s reaches 1, the final step is taken and the block goes → DONE.
- DONE: out_valid=1, out=acc (or saturation value). When out_ready=1, → IDLE. out, ovf and err stay stable while out_valid=1 and out_ready=0.
- Arithmetic: the codebase add_sub, mult and div units, round as those units do. Loop counters i (4 bit) and s (4 bit) are unsigned.

## Timing
- Reset values: in_ready=1 after reset release, out_valid=0, out=0x00000000, ovf=0, err=0, state IDLE.
- Latency from accept edge to out_valid: 2 + N_TERMS + s cycles, or 2 cycles on saturation/special.
- Throughput: one operation in flight; in_ready=0 from accept until DONE handshake.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- A new accept can occur no earlier than the cycle after the DONE handshake.
- rst_n assertion in any state aborts immediately. All registers return to reset values. No stale out_valid may appear after release.

## Configuration
- TAYLOR_EXP_SPECIAL_EN defined: REDUCE checks specials first and → DONE with err=1:
  - ln_in NaN or n_in==0 → 0x7FC00000
  - ln_in +Inf → 0x7F800000
  - ln_in −Inf → 0x00000000
- Undefined: no special detection. Specials flow through the arithmetic with undefined result. err tied 0. ovf saturation still active.

## Structure
- Package taylor_pkg:
  - state enum
  - constants FP_ONE=0x3F800000, FP_POS_INF=0x7F800000, FP_QNAN=0x7FC00000, FP_ZERO
  - function u8_to_fp32 (leading-one conversion of n, also used for i)
- Sub-module exp_horner_step: combinational mult → div → add_sub computing 1 + (r·acc)/i. Squaring uses a separate mult instance.

## Test plan
- ln_in=0x00000000, n_in=2 → out=0x3F800000 exactly, ovf=0, err=0, out_valid 12 cycles after accept (N_TERMS=10, s=0).
- ln_in=0x3FB17218 (ln 4), n_in=2 → out=0x40000000 ±4 ulp. y≈0.693 gives e=126, so s=1 and latency 13.
- ln_in=0xBF317218 (−ln 2), n_in=1 → out=0x3F000000 ±4 ulp.
- ln_in=0x43000000 (128.0), n_in=1 → s=9 > MAX_SQ, out=0x7F800000, ovf=1, latency 2. Same input with sign bit set → out=0x00000000, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out, ovf and err stable, in_ready=0, in_valid ignored. Accept on cycle 6 → in_ready=1 next cycle.
- Reset during HORNER (rst_n low 1 cycle) → out_valid=0, in_ready=1 after release. Then with TAYLOR_EXP_SPECIAL_EN defined: ln_in=0x7FC00000 → out=0x7FC00000, err=1; n_in=0 → out=0x7FC00000, err=1.

Source files
------------

// File: rtl/taylor_pkg.sv
// Shared types, IEEE-754 constants and single-precision arithmetic for the exp stage.
// Denormals flush to zero; all operations round to nearest-even.
package taylor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_REDUCE,
    S_HORNER,
    S_SQUARE,
    S_DONE
  } state_e;

  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  function automatic logic [31:0] u8_to_fp32(input logic [7:0] n);
    int          pos;
    logic [22:0] frac;
    if (n == 8'd0) return FP_ZERO;
    pos = 0;
    for (int k = 0; k < 8; k++) if (n[k]) pos = k;
    frac = {15'h0, n} << (23 - pos);
    return {1'b0, 8'(127 + pos), frac};
  endfunction

  function automatic logic [31:0] fp_pack(input logic sgn, input int ex_in,
                                          input logic [23:0] man, input logic grd,
                                          input logic stk);
    logic [24:0] mr;
    int          ex;
    ex = ex_in;
    mr = {1'b0, man} + {24'h0, grd & (stk | man[0])};
    if (mr[24]) begin
      mr = {1'b0, mr[24:1]};
      ex = ex + 1;
    end
    if (ex >= 255) return {sgn, 8'hFF, 23'h0};
    if (ex <= 0) return {sgn, 31'h0};
    return {sgn, ex[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] p;
    int          ex;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {sgn, 31'h0};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {sgn, 8'hFF, 23'h0};
    p  = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    ex = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return fp_pack(sgn, ex + 1, p[47:24], p[23], |p[22:0]);
    return fp_pack(sgn, ex, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [49:0] num, den, q, rm;
    int          ex;
    sgn = a[31] ^ b[31];
    if (b[30:23] == 8'h00) return {sgn, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00) return {sgn, 31'h0};
    if (a[30:23] == 8'hFF) return {sgn, 8'hFF, 23'h0};
    if (b[30:23] == 8'hFF) return {sgn, 31'h0};
    num = {1'b1, a[22:0], 26'h0};
    den = {26'h0, 1'b1, b[22:0]};
    q   = num / den;
    rm  = num % den;
    ex  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[26]) return fp_pack(sgn, ex, q[26:3], q[2], (|q[1:0]) | (rm != 50'h0));
    return fp_pack(sgn, ex - 1, q[25:2], q[1], q[0] | (rm != 50'h0));
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, ms;
    logic [27:0] sum;
    logic [7:0]  d;
    int          ex, lead;
    if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? FP_ZERO : b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // guard/round/sticky live in the three low bits of the aligned operand
    if (d > 8'd26) begin
      ms = 27'd1;
    end else begin
      ms    = my >> d;
      ms[0] = ms[0] | (|(my & ((27'd1 << d) - 27'd1)));
    end
    ex = int'(x[30:23]);
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, ms};
    else                sum = {1'b0, mx} - {1'b0, ms};
    if (sum == 28'h0) return FP_ZERO;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      ex  = ex + 1;
    end else begin
      lead = 0;
      for (int k = 0; k < 27; k++) if (sum[k]) lead = k;
      sum = sum << (26 - lead);
      ex  = ex - (26 - lead);
    end
    return fp_pack(x[31], ex, sum[26:3], sum[2], |sum[1:0]);
  endfunction

endpackage

// File: rtl/taylor_exp_horner_step.sv
// One Horner iteration of the exp series: acc_o = 1 + (r * acc) / i.
module exp_horner_step
  import taylor_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [31:0] acc_i,
  input  logic [3:0]  i_i,
  output logic [31:0] acc_o
);

  logic [31:0] prod;
  logic [31:0] quot;

  assign prod  = fp_mul(r_i, acc_i);
  assign quot  = fp_div(prod, u8_to_fp32({4'h0, i_i}));
  assign acc_o = fp_add(FP_ONE, quot);

endmodule

// File: rtl/taylor_exp_seq.sv
// Sequential x^(1/n) = exp(ln_in / n_in): divide, range-reduce, Horner exp, square back.
// Optional special-value handling is enabled with the TAYLOR_EXP_SPECIAL_EN macro.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a new ln_in / n_in
// S_DIV    | y = ln_in / float(n_in)
// S_REDUCE | split y into r and squaring count s, or saturate/special
// S_HORNER | acc = 1 + r*acc/i, one term per cycle, i counting down
// S_SQUARE | acc = acc*acc, s counting down
// S_DONE   | result held on out until out_ready
module taylor_exp_seq
  import taylor_pkg::*;
#(
  parameter int N_TERMS = 10,
  parameter int MAX_SQ  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ln_in,
  input  logic [7:0]  n_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        ovf,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] ln_q, ln_d;
  logic [7:0]  n_q, n_d;
  logic [31:0] y_q, y_d;
  logic [31:0] r_q, r_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  s_q, s_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic [31:0] horner_acc;
  logic [31:0] square_acc;
  logic [7:0]  s_full;
  logic        special_hit;
  logic [31:0] special_val;

  exp_horner_step u_horner (
    .r_i   (r_q),
    .acc_i (acc_q),
    .i_i   (i_q),
    .acc_o (horner_acc)
  );

  assign square_acc = fp_mul(acc_q, acc_q);
  assign s_full     = y_q[30:23] - 8'd125;

`ifdef TAYLOR_EXP_SPECIAL_EN
  always_comb begin
    special_hit = 1'b1;
    special_val = FP_QNAN;
    if (n_q == 8'd0 || (ln_q[30:23] == 8'hFF && ln_q[22:0] != 23'h0)) begin
      special_val = FP_QNAN;
    end else if (ln_q[30:23] == 8'hFF) begin
      special_val = ln_q[31] ? FP_ZERO : FP_POS_INF;
    end else begin
      special_hit = 1'b0;
    end
  end
`else
  assign special_hit = 1'b0;
  assign special_val = FP_ZERO;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ln_q    <= '0;
      n_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ln_q    <= ln_d;
      n_q     <= n_d;
      y_q     <= y_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ln_d    = ln_q;
    n_d     = n_q;
    y_d     = y_q;
    r_d     = r_q;
    acc_d   = acc_q;
    i_d     = i_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ln_d    = ln_in;
          n_d     = n_in;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        y_d     = fp_div(ln_q, u8_to_fp32(n_q));
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        if (special_hit) begin
          acc_d   = special_val;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (y_q[30:23] > 8'd125 && s_full > 8'(MAX_SQ)) begin
          acc_d   = y_q[31] ? FP_ZERO : FP_POS_INF;
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          // exponent 125 keeps |r| in [0.25, 0.5) so the series converges fast
          if (y_q[30:23] > 8'd125) begin
            s_d = s_full[3:0];
            r_d = {y_q[31], 8'd125, y_q[22:0]};
          end else begin
            s_d = 4'd0;
            r_d = y_q;
          end
          acc_d   = FP_ONE;
          i_d     = 4'(N_TERMS);
          state_d = S_HORNER;
        end
      end
      S_HORNER: begin
        acc_d = horner_acc;
        i_d   = i_q - 4'd1;
        if (i_q == 4'd1) state_d = (s_q != 4'd0) ? S_SQUARE : S_DONE;
      end
      S_SQUARE: begin
        acc_d = square_acc;
        s_d   = s_q - 4'd1;
        if (s_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = acc_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_taylor_exp_seq.sv
// Scoreboard bench for taylor_exp_seq: expectations queued at issue, popped at out_valid.
module tb_taylor_exp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] ln_in = 32'h0;
  logic [7:0]  n_in = 8'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        ovf;
  logic        err;

  typedef struct {
    logic [31:0] val;
    int          tol;   // <0: compare sign and exponent only
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  taylor_exp_seq #(.N_TERMS(10), .MAX_SQ(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ln_in     (ln_in),
    .n_in      (n_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic int ulp_dist(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  task automatic issue(input logic [31:0] ln, input logic [7:0] n, input logic [31:0] val,
                       input int tol, input logic o, input logic e, input int lat);
    exp_t x;
    x.val = val; x.tol = tol; x.ovf = o; x.err = e; x.lat = lat;
    sb.push_back(x);
    @(negedge clk);
    ln_in = ln; n_in = n; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset out: got %h want 00000000", out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b want 0", ovf); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
  endtask

  task automatic test_unity();
    logic [7:0] ns[4];
    int lat;
    exp_t e;
    ns = '{8'd2, 8'd1, 8'd7, 8'd255};
    for (int k = 0; k < 4; k++) begin
      issue(32'h0, ns[k], 32'h3F80_0000, 0, 1'b0, 1'b0, 12);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL unity[%0d] latency: got %0d want %0d", k, lat, e.lat); end
      checks++; if (out !== e.val) begin errors++; $display("FAIL unity[%0d] out: got %h want %h", k, out, e.val); end
      checks++; if (ovf !== e.ovf || err !== e.err) begin errors++; $display("FAIL unity[%0d] flags: got ovf=%b err=%b want 0 0", k, ovf, err); end
      handshake();
    end
  endtask

  task automatic test_roots();
    logic [31:0] lns[3], vals[3];
    logic [7:0]  ns[3];
    int lat;
    exp_t e;
    lns  = '{32'h3FB1_7218, 32'hBF31_7218, 32'hBFB1_7218};
    ns   = '{8'd2, 8'd1, 8'd2};
    vals = '{32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000};
    for (int k = 0; k < 3; k++) begin
      issue(lns[k], ns[k], vals[k], 4, 1'b0, 1'b0, 13);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL roots[%0d] latency: got %0d want %0d", k, lat, e.lat); end
      checks++; if (out[31] !== e.val[31] || ulp_dist(out, e.val) > e.tol) begin errors++; $display("FAIL roots[%0d] out: got %h want %h +-%0d ulp", k, out, e.val, e.tol); end
      checks++; if (ovf !== e.ovf || err !== e.err) begin errors++; $display("FAIL roots[%0d] flags: got ovf=%b err=%b want 0 0", k, ovf, err); end
      handshake();
    end
  endtask

  task automatic test_saturate();
    logic [31:0] lns[3], vals[3];
    logic [7:0]  ns[3];
    logic        ovfs[3];
    int          lats[3], tols[3];
    int lat;
    exp_t e;
    lns  = '{32'h4300_0000, 32'hC300_0000, 32'h4300_0000};
    ns   = '{8'd1, 8'd1, 8'd2};
    vals = '{32'h7F80_0000, 32'h0000_0000, 32'h6D80_0000};
    ovfs = '{1'b1, 1'b1, 1'b0};
    lats = '{2, 2, 20};
    tols = '{0, 0, -1};
    for (int k = 0; k < 3; k++) begin
      issue(lns[k], ns[k], vals[k], tols[k], ovfs[k], 1'b0, lats[k]);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL sat[%0d] latency: got %0d want %0d", k, lat, e.lat); end
      checks++;
      if ((e.tol < 0) ? (out[31:23] !== e.val[31:23]) : (out !== e.val)) begin
        errors++; $display("FAIL sat[%0d] out: got %h want %h", k, out, e.val);
      end
      checks++; if (ovf !== e.ovf || err !== e.err) begin errors++; $display("FAIL sat[%0d] flags: got ovf=%b err=%b want ovf=%b err=0", k, ovf, err, e.ovf); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    logic stable;
    issue(32'h0, 8'd2, 32'h3F80_0000, 0, 1'b0, 1'b0, 12);
    wait_out(lat);
    e = sb.pop_front();
    checks++; if (out !== e.val || lat != e.lat) begin errors++; $display("FAIL bp first result: got %h lat %0d want %h lat %0d", out, lat, e.val, e.lat); end
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; ln_in = 32'h4300_0000; n_in = 8'd1;
      @(posedge clk);
      #1;
      if (out !== e.val || ovf !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp hold: got out=%h ovf=%b err=%b in_ready=%b out_valid=%b", out, ovf, err, in_ready, out_valid); end
    in_valid = 1'b0;
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_abort();
    int lat;
    exp_t e;
    logic stale;
    issue(32'h3FB1_7218, 8'd2, 32'h4000_0000, 4, 1'b0, 1'b0, 13);
    void'(sb.pop_back());
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort in reset: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    @(negedge clk) rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL abort stale: got out_valid=%b in_ready=%b after release", out_valid, in_ready); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL abort out: got %h want 00000000", out); end
    issue(32'h0, 8'd3, 32'h3F80_0000, 0, 1'b0, 1'b0, 12);
    wait_out(lat);
    e = sb.pop_front();
    checks++; if (out !== e.val || lat != e.lat) begin errors++; $display("FAIL abort recover: got %h lat %0d want %h lat %0d", out, lat, e.val, e.lat); end
    handshake();
  endtask

`ifdef TAYLOR_EXP_SPECIAL_EN
  task automatic test_special();
    logic [31:0] lns[4], vals[4];
    logic [7:0]  ns[4];
    int lat;
    exp_t e;
    lns  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000};
    ns   = '{8'd2, 8'd0, 8'd3, 8'd3};
    vals = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000};
    for (int k = 0; k < 4; k++) begin
      issue(lns[k], ns[k], vals[k], 0, 1'b0, 1'b1, 2);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL special[%0d] latency: got %0d want %0d", k, lat, e.lat); end
      checks++; if (out !== e.val) begin errors++; $display("FAIL special[%0d] out: got %h want %h", k, out, e.val); end
      checks++; if (err !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL special[%0d] flags: got err=%b ovf=%b want 1 0", k, err, ovf); end
      handshake();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unity();
    test_roots();
    test_saturate();
    test_backpressure();
    test_reset_abort();
`ifdef TAYLOR_EXP_SPECIAL_EN
    test_special();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
